// File: rtl/stream_ch_ctrl.sv
// rtl/stream_ch_ctrl.sv - multi-channel DMA <-> streaming FIFO transfer controller
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, abort_i      single-cycle control pulses
//   ch_en_i, ch_type_i    per-channel enable / direction (1 = write, 0 = read), latched on start
//   len_i                 per-channel word count, latched on start (N_DMA_CH x CNT_W, ch0 in LSBs)
//   dma_push_i/dma_data_i DMA push request and data (read channels)
//   dma_pop_i             DMA pop request (write channels)
//   dma_ready_o           channel can move a word this cycle
//   fifo_push_o/fifo_data_o push request and data toward streaming read FIFOs
//   fifo_pop_o            pop request toward streaming write FIFOs
//   fifo_full_i/fifo_empty_i streaming FIFO status
//   busy_o, done_o        RUN indicator, one-cycle completion pulse
//   ch_cnt_o              per-channel transferred word count (ch0 in LSBs)
module stream_ch_ctrl #(
    parameter int N_DMA_CH = 4,
    parameter int N_BITS   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [N_DMA_CH-1:0]          ch_en_i,
    input  logic [N_DMA_CH-1:0]          ch_type_i,
    input  logic [N_DMA_CH*CNT_W-1:0]    len_i,
    input  logic [N_DMA_CH-1:0]          dma_push_i,
    input  logic [N_DMA_CH*N_BITS-1:0]   dma_data_i,
    input  logic [N_DMA_CH-1:0]          dma_pop_i,
    output logic [N_DMA_CH-1:0]          dma_ready_o,
    output logic [N_DMA_CH-1:0]          fifo_push_o,
    output logic [N_DMA_CH*N_BITS-1:0]   fifo_data_o,
    output logic [N_DMA_CH-1:0]          fifo_pop_o,
    input  logic [N_DMA_CH-1:0]          fifo_full_i,
    input  logic [N_DMA_CH-1:0]          fifo_empty_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [N_DMA_CH*CNT_W-1:0]    ch_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_DMA_CH-1:0]   en_q, en_d;
    logic [N_DMA_CH-1:0]   type_q, type_d;
    logic [CNT_W-1:0]      len_q [N_DMA_CH];
    logic [CNT_W-1:0]      len_d [N_DMA_CH];
    logic [CNT_W-1:0]      cnt_q [N_DMA_CH];
    logic [CNT_W-1:0]      cnt_d [N_DMA_CH];

    logic [N_DMA_CH-1:0]   active;
    logic [N_DMA_CH-1:0]   ready;
    logic [N_DMA_CH-1:0]   xfer;
    logic [CNT_W-1:0]      cnt_nxt [N_DMA_CH];
    logic                  all_done;

    // Per-channel handshake. A channel is only active in RUN and while
    // words remain, so an exhausted channel can never overrun its count.
    always_comb begin
        active      = '0;
        ready       = '0;
        xfer        = '0;
        fifo_push_o = '0;
        fifo_pop_o  = '0;
        all_done    = 1'b1;
        for (int i = 0; i < N_DMA_CH; i++) begin
            active[i] = (state_q == ST_RUN) && en_q[i] && (cnt_q[i] < len_q[i]);
            if (type_q[i]) begin
                ready[i]      = active[i] & ~fifo_empty_i[i];
                fifo_pop_o[i] = dma_pop_i[i] & ready[i];
                xfer[i]       = fifo_pop_o[i];
            end else begin
                ready[i]       = active[i] & ~fifo_full_i[i];
                fifo_push_o[i] = dma_push_i[i] & ready[i];
                xfer[i]        = fifo_push_o[i];
            end
            cnt_nxt[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, xfer[i]};
            // Completion is judged on the post-edge counts so done_o
            // appears in the cycle right after the last transfer.
            if (en_q[i] && (cnt_nxt[i] != len_q[i])) begin
                all_done = 1'b0;
            end
        end
    end

    assign dma_ready_o = ready;
    assign fifo_data_o = dma_data_i;
    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);

    always_comb begin
        for (int i = 0; i < N_DMA_CH; i++) begin
            ch_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        type_d  = type_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (ch_en_i != '0) begin
                        state_d = ST_RUN;
                        en_d    = ch_en_i;
                        type_d  = ch_type_i;
                        for (int i = 0; i < N_DMA_CH; i++) begin
                            len_d[i] = len_i[i*CNT_W +: CNT_W];
                            cnt_d[i] = '0;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // A transfer in the abort cycle is still counted.
                cnt_d = cnt_nxt;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (all_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            type_q  <= '0;
            for (int i = 0; i < N_DMA_CH; i++) begin
                len_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            type_q  <= type_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_ch_ctrl.sv
// tb/tb_stream_ch_ctrl.sv - self-checking bench for stream_ch_ctrl
module tb_stream_ch_ctrl;

    localparam int N  = 4;
    localparam int NB = 32;
    localparam int CW = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              abort_i;
    logic [N-1:0]      ch_en_i;
    logic [N-1:0]      ch_type_i;
    logic [N*CW-1:0]   len_i;
    logic [N-1:0]      dma_push_i;
    logic [N*NB-1:0]   dma_data_i;
    logic [N-1:0]      dma_pop_i;
    logic [N-1:0]      dma_ready_o;
    logic [N-1:0]      fifo_push_o;
    logic [N*NB-1:0]   fifo_data_o;
    logic [N-1:0]      fifo_pop_o;
    logic [N-1:0]      fifo_full_i;
    logic [N-1:0]      fifo_empty_i;
    logic              busy_o;
    logic              done_o;
    logic [N*CW-1:0]   ch_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    stream_ch_ctrl #(.N_DMA_CH(N), .N_BITS(NB), .CNT_W(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .ch_en_i      (ch_en_i),
        .ch_type_i    (ch_type_i),
        .len_i        (len_i),
        .dma_push_i   (dma_push_i),
        .dma_data_i   (dma_data_i),
        .dma_pop_i    (dma_pop_i),
        .dma_ready_o  (dma_ready_o),
        .fifo_push_o  (fifo_push_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_pop_o   (fifo_pop_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_empty_i (fifo_empty_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ch_cnt_o     (ch_cnt_o)
    );

    typedef struct {
        logic          start;
        logic          abort;
        logic [N-1:0]  en;
        logic [N-1:0]  typ;
        logic [63:0]   lens;
        logic [N-1:0]  push;
        logic [N-1:0]  pop;
        logic [N-1:0]  full;
        logic [N-1:0]  empty;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_push;
        logic [N-1:0]  e_pop;
        logic          e_busy;
        logic          e_done;
        logic [63:0]   e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic logic [63:0] q4(input int c3, input int c2, input int c1, input int c0);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    function automatic vec_t mk(input logic st, input logic ab, input logic [3:0] en,
                                input logic [3:0] typ, input logic [63:0] lens,
                                input logic [3:0] push, input logic [3:0] pop,
                                input logic [3:0] full, input logic [3:0] empty,
                                input logic [3:0] e_ready, input logic [3:0] e_push,
                                input logic [3:0] e_pop, input logic e_busy,
                                input logic e_done, input logic [63:0] e_cnt);
        vec_t v;
        v.start = st;  v.abort = ab; v.en = en; v.typ = typ; v.lens = lens;
        v.push = push; v.pop = pop;  v.full = full; v.empty = empty;
        v.e_ready = e_ready; v.e_push = e_push; v.e_pop = e_pop;
        v.e_busy = e_busy;   v.e_done = e_done; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] e_ready, input logic [3:0] e_push,
                                 input logic [3:0] e_pop, input logic e_busy, input logic e_done,
                                 input logic [63:0] e_cnt);
        chk({tag, " ready"}, 128'(dma_ready_o), 128'(e_ready));
        chk({tag, " push"},  128'(fifo_push_o), 128'(e_push));
        chk({tag, " pop"},   128'(fifo_pop_o),  128'(e_pop));
        chk({tag, " busy"},  128'(busy_o),      128'(e_busy));
        chk({tag, " done"},  128'(done_o),      128'(e_done));
        chk({tag, " cnt"},   128'(ch_cnt_o),    128'(e_cnt));
    endtask

    // Drive one cycle's inputs, sample at the falling edge, advance past the rising edge.
    task automatic run_row(input vec_t v, input string tag);
        logic [N*NB-1:0] data;
        data = {$urandom, $urandom, $urandom, $urandom};
        start_i = v.start;  abort_i = v.abort;
        ch_en_i = v.en;     ch_type_i = v.typ; len_i = v.lens;
        dma_push_i = v.push; dma_pop_i = v.pop;
        fifo_full_i = v.full; fifo_empty_i = v.empty;
        dma_data_i = data;
        @(negedge clk_i);
        check_outputs(tag, v.e_ready, v.e_push, v.e_pop, v.e_busy, v.e_done, v.e_cnt);
        chk({tag, " data"}, 128'(fifo_data_o), 128'(data));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [63:0] l5, l6, l1, lmix, lov, l9, c40;

        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        ch_en_i = '0; ch_type_i = '0; len_i = '0;
        dma_push_i = '1; dma_pop_i = '1; dma_data_i = '0;
        fifo_full_i = '0; fifo_empty_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_outputs("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 64'h0);
        @(posedge clk_i);
        #1;

        l5   = q4(0, 0, 0, 5);
        l6   = q4(0, 0, 0, 6);
        l1   = q4(0, 0, 0, 1);
        lmix = q4(4, 0, 1, 3);
        lov  = q4(0, 0, 3, 1);
        l9   = q4(9, 9, 9, 9);
        c40  = q4(4, 0, 1, 3);

        // Read channel 0, five words, no backpressure.
        vq.push_back(mk(1, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0));
        for (int k = 1; k <= 5; k++)
            vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, q4(0, 0, 0, k - 1)));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, l5));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l5));

        // Same transfer with fifo_full in transfer cycles 2-3.
        vq.push_back(mk(1, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l5));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, q4(0, 0, 0, 0)));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, q4(0, 0, 0, 1)));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, q4(0, 0, 0, 1)));
        for (int k = 1; k <= 4; k++)
            vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, q4(0, 0, 0, k)));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, l5));
        vq.push_back(mk(0, 0, 4'h1, 4'h0, l5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l5));

        // Mixed: ch0/ch1 read (3,1), ch2 write len 0, ch3 write len 4.
        vq.push_back(mk(1, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l5));
        vq.push_back(mk(0, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'hb, 4'h3, 4'h8, 1, 0, q4(0, 0, 0, 0)));
        vq.push_back(mk(0, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'h9, 4'h1, 4'h8, 1, 0, q4(1, 0, 1, 1)));
        vq.push_back(mk(0, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'h9, 4'h1, 4'h8, 1, 0, q4(2, 0, 1, 2)));
        vq.push_back(mk(0, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'h8, 4'h0, 4'h8, 1, 0, q4(3, 0, 1, 3)));
        vq.push_back(mk(0, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, c40));
        vq.push_back(mk(0, 0, 4'hf, 4'hc, lmix, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, c40));

        foreach (vq[i]) run_row(vq[i], $sformatf("vec%0d", i));

        // Abort in the same cycle as the final transfer: counted, no done.
        run_row(mk(1, 0, 4'h1, 4'h0, l1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, c40), "abw0");
        run_row(mk(0, 1, 4'h1, 4'h0, l1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, 64'h0), "abw1");
        run_row(mk(0, 0, 4'h1, 4'h0, l1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l1), "abw2");
        run_row(mk(0, 0, 4'h1, 4'h0, l1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l1), "abw3");

        // Abort after 2 of 6 words; counters hold, next start clears them.
        run_row(mk(1, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, l1), "ab0");
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, 64'h0), "ab1");
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, q4(0, 0, 0, 1)), "ab2");
        run_row(mk(0, 1, 4'h1, 4'h0, l6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1, 0, q4(0, 0, 0, 2)), "ab3");
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, q4(0, 0, 0, 2)), "ab4");
        run_row(mk(0, 1, 4'h1, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, q4(0, 0, 0, 2)), "ab5");
        run_row(mk(1, 0, 4'h1, 4'h0, l6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, q4(0, 0, 0, 2)), "ab6");
        run_row(mk(0, 1, 4'h1, 4'h0, l6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1, 0, 64'h0), "ab7");
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0), "ab8");

        // Start with no channels enabled: straight to DONE.
        run_row(mk(1, 0, 4'h0, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0), "zen0");
        run_row(mk(0, 0, 4'h0, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 64'h0), "zen1");
        run_row(mk(0, 0, 4'h0, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0), "zen2");

        // Overrun on an exhausted channel and a start during RUN with new lengths.
        run_row(mk(1, 0, 4'h3, 4'h0, lov, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0), "ov0");
        run_row(mk(1, 0, 4'h3, 4'h0, l9,  4'h3, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0, 1, 0, 64'h0), "ov1");
        run_row(mk(0, 0, 4'h3, 4'h0, l9,  4'h3, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 1, 0, q4(0, 0, 1, 1)), "ov2");
        run_row(mk(0, 0, 4'h3, 4'h0, l9,  4'h3, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 1, 0, q4(0, 0, 2, 1)), "ov3");
        run_row(mk(0, 0, 4'h3, 4'h0, l9,  4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, lov), "ov4");
        run_row(mk(0, 0, 4'h3, 4'h0, l9,  4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, lov), "ov5");

        // Reset in the middle of RUN.
        run_row(mk(1, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, lov), "rst0");
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, 64'h0), "rst1");
        rst_i = 1'b1;
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1, 0, q4(0, 0, 0, 1)), "rst2");
        rst_i = 1'b0;
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0), "rst3");
        run_row(mk(0, 0, 4'h1, 4'h0, l6, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 64'h0), "rst4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_ch_ctrl.md
STREAM_CH_CTRL -- requirements
Module: stream_ch_ctrl

Interface
REQ-001 Parameter N_DMA_CH, default 4: number of DMA hardware-FIFO channels.
REQ-002 Parameter N_BITS, default 32: data word width.
REQ-003 Parameter CNT_W, default 16: transfer-length and counter width.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk_i and rst_i.
REQ-005 clk_i  in  1  block clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 start_i  in  1  single-cycle pulse that starts a transfer.
REQ-008 abort_i  in  1  single-cycle pulse that cancels a running transfer.
REQ-009 ch_en_i  in  N_DMA_CH  per-channel enable; sampled when start_i is accepted.
REQ-010 ch_type_i  in  N_DMA_CH  per-channel direction (1 = write/output channel, 0 = read/input channel); sampled when start_i is accepted.
REQ-011 len_i  in  N_DMA_CH x CNT_W  per-channel word count; sampled when start_i is accepted.
REQ-012 dma_push_i / dma_data_i  in  N_DMA_CH / N_DMA_CH x N_BITS  DMA write-to-FIFO request and data (read channels only).
REQ-013 dma_pop_i  in  N_DMA_CH  DMA pop request (write channels only).
REQ-014 dma_ready_o  out  N_DMA_CH  channel can transfer a word this cycle.
REQ-015 fifo_push_o / fifo_data_o  out  N_DMA_CH / N_DMA_CH x N_BITS  push request and data toward the streaming-interface read FIFOs.
REQ-016 fifo_pop_o  out  N_DMA_CH  pop request toward the streaming-interface write FIFOs.
REQ-017 fifo_full_i / fifo_empty_i  in  N_DMA_CH each  full and empty status from the streaming interface.
REQ-018 busy_o  out  1  high while the state is RUN.
REQ-019 done_o  out  1  single-cycle completion pulse.
REQ-020 ch_cnt_o  out  N_DMA_CH x CNT_W  per-channel count of words transferred.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN, DONE; the encoding is free.
REQ-022 Transitions out of IDLE:
- start_i with (ch_en_i != 0): go to RUN; latch ch_en_i, ch_type_i and len_i; clear all counters.
- start_i with ch_en_i == 0: go to DONE.
REQ-023 In RUN, channel i SHALL be active when it is enabled and cnt[i] < len[i]; a channel with len = 0 is complete immediately.
REQ-024 Read channel (type 0), all combinational with zero latency:
- dma_ready_o[i] = active & ~fifo_full_i[i].
- fifo_push_o[i] = dma_push_i[i] & dma_ready_o[i].
- fifo_data_o[i] = dma_data_i[i].
REQ-025 Write channel (type 1), all combinational with zero latency:
- dma_ready_o[i] = active & ~fifo_empty_i[i].
- fifo_pop_o[i] = dma_pop_i[i] & dma_ready_o[i].
REQ-026 fifo_push_o SHALL be 0 on write channels, and fifo_pop_o SHALL be 0 on read channels.
REQ-027 cnt[i] SHALL increment by 1 on the clock edge of each accepted transfer. It never exceeds len[i] and never wraps.
REQ-028 RUN SHALL go to DONE on the edge after which every enabled channel has cnt = len. If the last transfers complete on edge t, done_o is high in cycle t+1.
REQ-029 DONE SHALL last exactly one cycle, with done_o = 1, then go to IDLE.
REQ-030 abort_i in RUN SHALL go to IDLE with no done_o pulse. Counters hold their values; outputs gate off in the next cycle.
REQ-031 Simultaneous events and ignored inputs:
- abort_i in the same cycle as the last transfer: abort wins and done_o is not asserted; that final transfer is still counted.
- start_i in RUN or DONE: ignored.
- abort_i in IDLE or DONE: ignored.
REQ-032 Outside RUN, dma_ready_o, fifo_push_o and fifo_pop_o SHALL all be 0, regardless of the dma_* inputs.
REQ-033 ch_cnt_o SHALL hold its value in IDLE until the next accepted start_i.
REQ-034 Disabled channels SHALL keep all of their outputs at 0, and their counters SHALL stay at 0.

Reset
REQ-035 On rst_i high at a clock edge, the block SHALL go to IDLE with all of the following cleared to 0:
- counters;
- latched ch_en, ch_type and len;
- busy_o and done_o.
REQ-036 Reset in the middle of RUN SHALL abandon the transfer with no done_o pulse, and all handshake outputs are 0 in the cycle after reset.
REQ-037 fifo_data_o is a combinational passthrough and is not reset.

Verification
REQ-038 Read channel 0: ch_en=0001, type=0000, len0=5, dma_push_i held high, fifo_full_i=0 -> five fifo_push_o cycles, ch_cnt_o[0]=5, done_o in the cycle after the 5th push, busy_o low afterwards.
REQ-039 Backpressure: the same transfer with fifo_full_i[0] high in cycles 2-3 -> dma_ready_o[0] and fifo_push_o[0] are 0 in those cycles, the counter stalls, and the transfer still completes at exactly 5 words.
REQ-040 Mixed channels: ch_en=1111, type=1100, lens=3,1,0,4, all requests high, FIFOs ready -> ch2 never handshakes, and done_o follows the 4th pop on ch3 only.
REQ-041 Abort: abort_i raised after 2 of 6 words -> IDLE, no done_o, ch_cnt_o=2, outputs 0; a new start_i clears the counters.
REQ-042 Edge cases: start_i with ch_en=0 -> done_o one cycle later. rst_i asserted mid-RUN -> no done_o and all outputs 0.
REQ-043 Overrun and ignored start: after cnt = len, continued dma_push_i/dma_pop_i produces no further fifo_push_o/fifo_pop_o. start_i issued during RUN leaves the latched len unchanged.
